// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR random generator.
//   - fill_state_e  : sample FSM encoding (ST_FILL, ST_VALID)
//   - TAPS_*        : maximal-length XNOR tap masks for common widths
//   - width limits and the OUT_W range check used at elaboration
package lfsr_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_VALID = 1'b1
  } fill_state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  localparam int unsigned LFSR_MIN_W = 3;
  localparam int unsigned LFSR_MAX_W = 32;
  localparam int unsigned OUT_W_MIN  = 1;

  function automatic bit out_w_legal(input int unsigned out_w, input int unsigned width);
    return (out_w >= OUT_W_MIN) && (out_w <= width);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: XNOR Fibonacci LFSR register with seed load and lock-up recovery.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           allow one shift per cycle
//   load_i/seed_i  load seed (all-ones seed is replaced by zero)
//   q_o            current state
//   q_nxt_o        state after a shift from q_o (valid whenever shift_o=1)
//   shift_o        a shift happens on this edge
//   lockup_o       one-cycle pulse after all-ones was replaced by zero
module lfsr_core #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_nxt_o,
  output logic             shift_o,
  output logic             lockup_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             lock_q, lock_d;
  logic             fb;
  logic             q_all_ones;
  logic             seed_all_ones;

  // Masked-off bits are zero and do not disturb the parity.
  assign fb            = ~^(q_q & TAPS);
  assign q_nxt_o       = {q_q[WIDTH-2:0], fb};
  assign q_all_ones    = &q_q;
  assign seed_all_ones = &seed_i;
  assign shift_o       = en_i & ~load_i & ~q_all_ones;

  always_comb begin
    q_d    = q_q;
    lock_d = 1'b0;
    if (load_i) begin
      if (seed_all_ones) begin
        q_d    = '0;
        lock_d = 1'b1;
      end else begin
        q_d = seed_i;
      end
    end else if (q_all_ones) begin
      // All-ones is the XNOR fixed point; clear it rather than shift.
      q_d    = '0;
      lock_d = 1'b1;
    end else if (en_i) begin
      q_d = q_nxt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q    <= '0;
      lock_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      lock_q <= lock_d;
    end
  end

  assign q_o      = q_q;
  assign lockup_o = lock_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: LFSR random source with a valid/ready sample port.
// Each sample is taken after OUT_W fresh shifts so consecutive words do not
// share bits.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   en_i                       shift enable (freezes LFSR and fill count)
//   load_i, seed_i             load seed; overrides shift and handshake
//   q_o                        current LFSR state
//   rand_data_o, rand_valid_o  sample and its valid flag
//   rand_ready_i               consumer accept
//   lockup_o                   pulse when all-ones was cleared
//   period_o, wrap_o           only with LFSR_PERIOD_CNT_EN: measured period
//                              and one-cycle pulse when Q returns to the
//                              last loaded seed (0 after reset)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_FILL  | counting enabled shifts toward the next OUT_W-bit sample
// ST_VALID | sample held on rand_data_o until accepted; LFSR free-runs
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
  parameter int unsigned      OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] q_o,
  output logic [OUT_W-1:0] rand_data_o,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic             lockup_o
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_o,
  output logic             wrap_o
`endif
);

  if (!out_w_legal(OUT_W, WIDTH) || (WIDTH < LFSR_MIN_W) || (WIDTH > LFSR_MAX_W)) begin : g_bad_cfg
    $error("lfsr_rand_gen: illegal WIDTH/OUT_W combination");
  end

  localparam int unsigned CW = $clog2(OUT_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             shift;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .load_i   (load_i),
    .seed_i   (seed_i),
    .q_o      (q_o),
    .q_nxt_o  (q_nxt),
    .shift_o  (shift),
    .lockup_o (lockup_o)
  );

  fill_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (load_i) begin
      // A reload restarts the fill and drops any pending sample.
      state_d = ST_FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (shift) begin
            if (cnt_q == CNT_LAST) begin
              data_d  = q_nxt[OUT_W-1:0];
              cnt_d   = '0;
              state_d = ST_VALID;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_VALID: begin
          if (rand_ready_i) state_d = ST_FILL;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign rand_data_o  = data_q;
  assign rand_valid_o = (state_q == ST_VALID);

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    pcnt_d   = pcnt_q;
    ref_d    = ref_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (load_i) begin
      pcnt_d = '0;
      // Reference is what actually lands in Q, so an all-ones seed maps to 0.
      ref_d  = (&seed_i) ? '0 : seed_i;
    end else if (shift) begin
      if (q_nxt == ref_q) begin
        wrap_d   = 1'b1;
        period_d = pcnt_q + WIDTH'(1);
        pcnt_d   = '0;
      end else begin
        pcnt_d = pcnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q   <= '0;
      ref_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period_o = period_q;
  assign wrap_o   = wrap_q;
`else
  // Only the low OUT_W bits of the look-ahead state are needed here.
  logic unused_q_nxt;
  assign unused_q_nxt = ^q_nxt;
`endif

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
- Parametrised XNOR Fibonacci LFSR with seed load, enable gating and lock-up recovery.
- Adds a valid/ready sample port that delivers OUT_W-bit random words; each word is decorrelated by OUT_W shifts.
- Successor to the fixed 8-bit LFSR. It feeds game logic such as arrow/lane selection and step timing jitter.

Parameters:
- WIDTH, 8, LFSR register width, legal 3..32.
- TAPS, 8'hB8, WIDTH-bit tap mask. Bit i set means Q[i] feeds the XNOR. Default taps are 7,5,4,3 (maximal, period 255).
- OUT_W, 4, sample width and shifts per sample, legal 1..WIDTH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  allows shifting; when low, the LFSR and fill counter freeze.
- Load  in  1  one-cycle request to load Seed.
- Seed  in  WIDTH  seed value, sampled when Load=1.
- Q  out  WIDTH  current LFSR state.
- Rand_data  out  OUT_W  sample, equal to Q[OUT_W-1:0] captured at the end of fill.
- Rand_valid  out  1  sample available.
- Rand_ready  in  1  consumer accepts the sample when Rand_valid and Rand_ready are both 1.
- Lockup  out  1  one-cycle pulse when all-ones was detected and forced clear.

Behaviour:
- Shift rule: in = XNOR of Q[i] over all set TAPS bits; next Q = {Q[WIDTH-2:0], in}.
- Reset: Q=0, Rand_data=0, Rand_valid=0, Lockup=0, fill count=0, FSM=FILL.
- FSM has two states:
  - FILL: each Enable=1 cycle shifts once and increments the count. On the shift that makes the count reach OUT_W, register Rand_data from the post-shift Q[OUT_W-1:0], set Rand_valid=1, clear the count and go to VALID.
  - VALID: Q keeps shifting while Enable=1 (free-running). Rand_data and Rand_valid are held until the handshake. On the handshake, Rand_valid=0 next cycle and the FSM returns to FILL.
  - Back-to-back throughput is one sample per OUT_W+1 cycles.
- Latency: the first Rand_valid rises OUT_W enabled cycles after Reset deasserts.
- Enable low: no shift and no count change. Rand_valid and Rand_data are held, and the handshake is still honoured.
- Load (priority over shift and over the handshake):
  - Q <= Seed next cycle and the count clears.
  - FSM goes to FILL and Rand_valid drops to 0; a pending sample is discarded even if Rand_ready=1 in the same cycle.
  - If Seed is all-ones, load all-zeros instead and pulse Lockup.
- Lock-up: all-ones is the XNOR lock-up state. If Q is ever all-ones with no Load, the next cycle forces Q=0 (no shift) and pulses Lockup. Normal operation never reaches this state; it is recovery only.
- Reset mid-fill or mid-valid: full return to reset values on the next edge, with no partial sample.
- Load while Enable=0 still loads.

Optional Feature:
- Macro: LFSR_PERIOD_CNT_EN.
- With the macro defined:
  - Adds a WIDTH-bit period counter and outputs Period (WIDTH) and Wrap (1).
  - The counter increments per shift and clears on Reset or Load.
  - When Q returns to the reference value (last loaded seed, or 0 after Reset), Wrap pulses for one cycle, Period latches count+1 and the counter clears.
- Without the macro: no counter and no Period/Wrap ports.

Decomposition:
- Package lfsr_pkg holds:
  - FSM state encoding (ST_FILL, ST_VALID);
  - default tap constants per width (TAPS_8=8'hB8, TAPS_16=16'hB400, TAPS_32=32'h80200003);
  - an OUT_W range-check constant.
- One sub-module, lfsr_core: a WIDTH/TAPS register with Enable, Load/Seed, lock-up clear and Lockup pulse, exposing Q. The top level adds the fill FSM, sample register and optional period counter.

Test Plan:
- Reset, Enable=1, Rand_ready=0, defaults: Q steps 0x01, 0x03, 0x07, 0x0F. Rand_valid rises with Rand_data=0xF in the 4th cycle after reset.
- Continue, pulse Rand_ready for one cycle: Rand_valid drops. After 4 shifts from the handshake, Rand_data holds the low nibble of Q at that point.
  - Separately, with Enable held high from reset, Q continues 0x1E, 0x3D, 0x7A, 0xF4.
- Load with Seed=0xFF: Q=0x00 next cycle, Lockup pulses once, Rand_valid=0.
- Load with Seed=0x5A while Rand_valid=1 and Rand_ready=1: the sample is discarded, Q=0x5A, fill restarts, and the next Rand_valid comes 4 cycles later.
- Enable low for 10 cycles mid-fill: Q and the count are frozen. After Enable returns, the remaining shifts complete the sample with no skip.
- With LFSR_PERIOD_CNT_EN, Reset then 255 enabled shifts: Wrap pulses exactly once and Period=255; 255 distinct Q values are seen and 0xFF is never seen.
